// File: rtl/persp_div_issuer.sv
`default_nettype none
// ============================================================================
// Module   : persp_div_issuer
// Purpose  : Perspective-divide requester. Accepts one vertex (x, y, z, w),
//            issues x/w, y/w, z/w to an in-order 16-bit signed divider and
//            returns the three quotients on a valid/ready output.
//            w == 0 bypasses the divider with sign-saturated results.
// Ports    : clk, rst                        - clock, sync active-high reset
//            in_valid/in_ready, in_x..in_w   - vertex input handshake
//            div_open, div_dividend/divisor  - divider request strobe + data
//            div_finish, div_quotient        - divider result strobe + data
//            out_valid/out_ready, out_x..z   - result vertex handshake
//            out_dz, out_timeout             - divide-by-zero / lost-result flags
// Revision : 1.0 - initial release
// ============================================================================
module persp_div_issuer #(
    parameter int TIMEOUT      = 64,
    parameter int FLUSH_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [15:0] in_z,
    input  logic [15:0] in_w,
    output logic        div_open,
    output logic [15:0] div_dividend,
    output logic [15:0] div_divisor,
    input  logic        div_finish,
    input  logic [15:0] div_quotient,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic [15:0] out_z,
    output logic        out_dz,
    output logic        out_timeout
);

    localparam int c_FW = $clog2(FLUSH_CYCLES + 1);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'(FLUSH_CYCLES - 1);
    // WAIT is entered one cycle after the last issue, so the abort fires when
    // the counter reaches TIMEOUT-2; out_valid then rises exactly TIMEOUT
    // cycles after the last div_open cycle.
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT - 2);

    localparam logic [2:0] c_S_FLUSH = 3'd0;
    localparam logic [2:0] c_S_IDLE  = 3'd1;
    localparam logic [2:0] c_S_ISSUE = 3'd2;
    localparam logic [2:0] c_S_WAIT  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [c_FW-1:0] r_flush_cnt;
    logic [c_TW-1:0] r_tmo_cnt;
    logic [1:0]      r_issue_idx;
    logic [1:0]      r_col_idx;
    logic [15:0]     r_y;
    logic [15:0]     r_z;

    logic w_fin_live;
    logic w_last_fin;

    // Finishes only count while a vertex is outstanding; anything else is a
    // stale result from an abandoned vertex.
    assign w_fin_live = div_finish && ((r_state == c_S_ISSUE) || (r_state == c_S_WAIT));
    assign w_last_fin = w_fin_live && (r_col_idx == 2'd2);

    function automatic logic [15:0] f_sat(input logic [15:0] v);
        if (v == 16'd0)
            return 16'h0000;
        else if (v[15])
            return 16'h8000;
        else
            return 16'h7FFF;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_FLUSH;
            r_flush_cnt  <= '0;
            r_tmo_cnt    <= '0;
            r_issue_idx  <= 2'd0;
            r_col_idx    <= 2'd0;
            r_y          <= 16'd0;
            r_z          <= 16'd0;
            in_ready     <= 1'b0;
            div_open     <= 1'b0;
            div_dividend <= 16'd0;
            div_divisor  <= 16'd0;
            out_valid    <= 1'b0;
            out_x        <= 16'd0;
            out_y        <= 16'd0;
            out_z        <= 16'd0;
            out_dz       <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            // In-order result capture, shared by ISSUE and WAIT.
            if (w_fin_live) begin
                case (r_col_idx)
                    2'd0:    out_x <= div_quotient;
                    2'd1:    out_y <= div_quotient;
                    default: out_z <= div_quotient;
                endcase
                r_col_idx <= r_col_idx + 2'd1;
            end

            case (r_state)
                c_S_FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_state  <= c_S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end

                c_S_IDLE: begin
                    if (in_valid) begin
                        in_ready    <= 1'b0;
                        r_y         <= in_y;
                        r_z         <= in_z;
                        r_col_idx   <= 2'd0;
                        out_timeout <= 1'b0;
                        if (in_w != 16'd0) begin
                            // First divide goes out directly from the accept
                            // edge; the divisor register doubles as latched w.
                            div_open     <= 1'b1;
                            div_dividend <= in_x;
                            div_divisor  <= in_w;
                            r_issue_idx  <= 2'd0;
                            out_x        <= 16'd0;
                            out_y        <= 16'd0;
                            out_z        <= 16'd0;
                            out_dz       <= 1'b0;
                            r_state      <= c_S_ISSUE;
                        end else begin
                            out_x     <= f_sat(in_x);
                            out_y     <= f_sat(in_y);
                            out_z     <= f_sat(in_z);
                            out_dz    <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= c_S_DONE;
                        end
                    end
                end

                c_S_ISSUE: begin
                    if (r_issue_idx == 2'd2) begin
                        div_open  <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= c_S_WAIT;
                    end else begin
                        r_issue_idx  <= r_issue_idx + 2'd1;
                        div_dividend <= (r_issue_idx == 2'd0) ? r_y : r_z;
                    end
                    // A zero-latency divider can return the third result
                    // while the last request is still on the bus.
                    if (w_last_fin) begin
                        div_open  <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= c_S_DONE;
                    end
                end

                c_S_WAIT: begin
                    if (w_last_fin) begin
                        out_valid <= 1'b1;
                        r_state   <= c_S_DONE;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        r_state     <= c_S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                c_S_DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_dz      <= 1'b0;
                        out_timeout <= 1'b0;
                        // Late results may still be in flight after a
                        // timeout, so drain the divider before reopening.
                        if (out_timeout) begin
                            r_flush_cnt <= '0;
                            r_state     <= c_S_FLUSH;
                        end else begin
                            in_ready <= 1'b1;
                            r_state  <= c_S_IDLE;
                        end
                    end
                end

                default: begin
                    r_flush_cnt <= '0;
                    r_state     <= c_S_FLUSH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_persp_div_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_persp_div_issuer
// Purpose  : Directed self-checking bench for persp_div_issuer with an
//            in-order divider model of configurable latency (0 = same-cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_persp_div_issuer;

    localparam int TIMEOUT      = 64;
    localparam int FLUSH_CYCLES = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = 16'd0;
    logic [15:0] in_y = 16'd0;
    logic [15:0] in_z = 16'd0;
    logic [15:0] in_w = 16'd0;
    logic        div_open;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_finish;
    logic [15:0] div_quotient;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [15:0] out_z;
    logic        out_dz;
    logic        out_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    persp_div_issuer #(
        .TIMEOUT      (TIMEOUT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_z         (in_z),
        .in_w         (in_w),
        .div_open     (div_open),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_finish   (div_finish),
        .div_quotient (div_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_z        (out_z),
        .out_dz       (out_dz),
        .out_timeout  (out_timeout)
    );

    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- divider model ----------------
    int          lat       = 3;
    bit          comb_mode = 1'b0;
    int          drop_at   = -1;
    int          push_n    = 0;
    int          q_due[$];
    logic [15:0] q_val[$];
    logic        fin_r = 1'b0;
    logic [15:0] quo_r = 16'd0;

    int          open_edge[$];
    logic [15:0] open_dvd[$];
    logic [15:0] open_dvs[$];
    int          fin_edge[$];

    function automatic logic [15:0] f_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0)
            return 16'd0;
        return 16'($signed(a) / $signed(b));
    endfunction

    always @(posedge clk) begin
        if (div_open) begin
            open_edge.push_back(cyc + 1);
            open_dvd.push_back(div_dividend);
            open_dvs.push_back(div_divisor);
            if (!comb_mode && (push_n != drop_at)) begin
                q_due.push_back(cyc + lat);
                q_val.push_back(f_div(div_dividend, div_divisor));
            end
            push_n <= push_n + 1;
        end
        if (div_finish)
            fin_edge.push_back(cyc + 1);
    end

    always @(negedge clk) begin
        if ((q_due.size() > 0) && (q_due[0] <= cyc)) begin
            fin_r <= 1'b1;
            quo_r <= q_val[0];
            void'(q_due.pop_front());
            void'(q_val.pop_front());
        end else begin
            fin_r <= 1'b0;
        end
    end

    always_comb begin
        div_finish   = fin_r;
        div_quotient = quo_r;
        if (comb_mode) begin
            div_finish   = div_open;
            div_quotient = f_div(div_dividend, div_divisor);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        open_edge.delete();
        open_dvd.delete();
        open_dvs.delete();
        fin_edge.delete();
    endtask

    // Presents a vertex and returns the edge on which it was accepted.
    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [15:0] w, output int acc);
        in_x = x; in_y = y; in_z = z; in_w = w;
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL accept_bound: in_ready never rose within 300 cycles");
        end
    endtask

    // Returns the edge after which out_valid was first seen high.
    task automatic wait_out(input int bound, output int e);
        e = -1;
        for (int i = 0; i < bound; i++) begin
            if (out_valid) begin
                e = cyc;
                break;
            end
            tick();
        end
        if (e < 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL out_valid_bound: no out_valid within %0d cycles", bound);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Back-to-back table: inputs and hand-computed truncating quotients.
    logic [15:0] vx[4] = '{16'd100,  16'hFFF9, 16'd1000, 16'h8000};
    logic [15:0] vy[4] = '{16'd200,  16'd7,    16'hFC19, 16'd5};
    logic [15:0] vz[4] = '{16'hFED4, 16'h7FFF, 16'd0,    16'hFFFB};
    logic [15:0] vw[4] = '{16'd10,   16'd2,    16'hFFFC, 16'd7};
    logic [15:0] ex[4] = '{16'd10,   16'hFFFD, 16'hFF06, 16'hEDB7};
    logic [15:0] ey[4] = '{16'd20,   16'd3,    16'h00F9, 16'd0};
    logic [15:0] ez[4] = '{16'hFFE2, 16'h3FFF, 16'd0,    16'd0};
    int          lats[3] = '{0, 1, 20};

    initial begin
        int a;
        int e;
        int seen;

        // ---- reset state and initial flush ----
        rst = 1'b1;
        tick(); tick(); tick();
        chk("reset_ctrl", {in_ready, out_valid, div_open, out_dz, out_timeout}, 5'b00000);
        chk("reset_data", {out_x, out_y, out_z}, 48'h0);
        chk("reset_div",  {div_dividend, div_divisor}, 32'h0);
        rst = 1'b0;
        repeat (FLUSH_CYCLES - 1) tick();
        chk("flush_not_ready", in_ready, 1'b0);
        tick();
        chk("flush_ready", in_ready, 1'b1);

        // ---- 1: basic divide, latency 3 ----
        lat = 3;
        clear_logs();
        send(16'd100, 16'hFFCE, 16'd7, 16'd5, a);
        wait_out(100, e);
        chk("t1_open_count", open_edge.size(), 3);
        if (open_edge.size() == 3) begin
            chk("t1_first_open", open_edge[0] - a, 1);
            chk("t1_open_span",  open_edge[2] - open_edge[0], 2);
            chk("t1_dividends",  {open_dvd[0], open_dvd[1], open_dvd[2]}, {16'd100, 16'hFFCE, 16'd7});
            chk("t1_divisors",   {open_dvs[0], open_dvs[1], open_dvs[2]}, {16'd5, 16'd5, 16'd5});
        end
        chk("t1_out_edge", e, a + 3 + lat);
        if (fin_edge.size() > 0)
            chk("t1_after_last_fin", e, fin_edge[fin_edge.size() - 1]);
        chk("t1_result", {out_x, out_y, out_z}, {16'd20, 16'hFFF6, 16'd1});
        chk("t1_flags",  {out_dz, out_timeout}, 2'b00);
        tick();
        chk("t1_release", {out_valid, in_ready}, 2'b01);

        // ---- 2: w == 0 saturation ----
        clear_logs();
        send(16'd5, 16'hFFFD, 16'd0, 16'd0, a);
        wait_out(5, e);
        chk("t2_out_edge", e, a);
        chk("t2_result", {out_x, out_y, out_z}, {16'h7FFF, 16'h8000, 16'h0000});
        chk("t2_flags",  {out_dz, out_timeout}, 2'b10);
        tick(); tick();
        chk("t2_no_open", open_edge.size(), 0);
        chk("t2_release", {out_valid, in_ready, out_dz}, 3'b010);

        // ---- 3: output backpressure ----
        out_ready = 1'b0;
        send(16'd12, 16'hFFF4, 16'hFFF9, 16'd3, a);
        wait_out(100, e);
        chk("t3_result", {out_x, out_y, out_z}, {16'd4, 16'hFFFC, 16'hFFFE});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold", {out_valid, in_ready, out_x, out_y, out_z},
                {1'b1, 1'b0, 16'd4, 16'hFFFC, 16'hFFFE});
        end
        out_ready = 1'b1;
        tick();
        chk("t3_accept", {out_valid, in_ready}, 2'b01);

        // ---- 4: reset during WAIT, stale finishes ignored ----
        lat = 20;
        clear_logs();
        send(16'd30, 16'd60, 16'd90, 16'd3, a);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < FLUSH_CYCLES - 1; i++) begin
            tick();
            if (out_valid || in_ready)
                seen++;
        end
        chk("t4_quiet_flush", seen, 0);
        tick();
        chk("t4_ready_after_flush", {in_ready, out_valid}, 2'b10);
        lat = 1;
        send(16'd8, 16'd16, 16'hFFE8, 16'hFFF8, a);
        wait_out(100, e);
        chk("t4_recover", {out_x, out_y, out_z, out_dz, out_timeout},
            {16'hFFFF, 16'hFFFE, 16'd3, 2'b00});
        tick();

        // ---- 5: missing third result -> timeout ----
        lat = 3;
        clear_logs();
        drop_at = push_n + 2;
        send(16'd9, 16'd18, 16'd27, 16'd9, a);
        wait_out(TIMEOUT + 40, e);
        if (open_edge.size() == 3)
            chk("t5_timeout_latency", e - (open_edge[2] - 1), TIMEOUT);
        chk("t5_result", {out_x, out_y, out_z}, {16'd1, 16'd2, 16'd0});
        chk("t5_flags",  {out_dz, out_timeout}, 2'b01);
        tick();
        chk("t5_handshake", {out_valid, in_ready, out_timeout}, 3'b000);
        repeat (FLUSH_CYCLES - 1) tick();
        chk("t5_flush_not_ready", in_ready, 1'b0);
        tick();
        chk("t5_flush_ready", in_ready, 1'b1);
        drop_at = -1;

        // ---- 6: back-to-back vertices at several divider latencies ----
        for (int l = 0; l < 3; l++) begin
            lat       = lats[l];
            comb_mode = (lats[l] == 0);
            for (int v = 0; v < 4; v++) begin
                clear_logs();
                send(vx[v], vy[v], vz[v], vw[v], a);
                wait_out(100, e);
                chk("t6_out_edge", e, a + 3 + lats[l]);
                chk("t6_result", {out_x, out_y, out_z, out_dz, out_timeout},
                    {ex[v], ey[v], ez[v], 2'b00});
            end
            tick();
        end
        comb_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
